cache_set: RTL and testbench

- One 8-way set-associative cache set: 64-byte lines, 24-bit tags, LRU replacement.
- Building block of the L1 data cache array; one instance per set index, selected by matching set_n against SET_ID.
- No backing memory: misses allocate a line, they never fetch one.
- Accepts one read, write or no-op per clock; results are registered.

---
 rtl/cache_set.sv | 180 ++++++++++++++++++
 tb/tb_cache_set.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_set.sv
`default_nettype none
// ============================================================================
// Module   : cache_set
// Purpose  : One 8-way set-associative cache set with 64-byte lines, 24-bit
//            tags and age-based LRU replacement. Write misses allocate a
//            zeroed line. Nothing is fetched and nothing is written back.
//            All results are registered and appear one cycle after the
//            request.
// Ports    : clk, rst_n         - clock and async active-low reset
//            enable[0]          - flush this set (clear valids, reset ages)
//            write_en           - 0 read, 1 write, others no-op
//            block_offset       - first byte of the access within the line
//            set_n              - request set index, compared against SET_ID
//            write_data         - little-endian write bytes
//            data_size          - access length is 2**data_size bytes
//            tag                - request tag
//            num_ops            - debug counter, not used
//            out_data           - read bytes, zero-extended to 128 bits
//            miss_w/miss_r      - bit0: last write/read missed
//            data_ready         - bit0: last read hit
// Revision : 1.0 - initial release
// ============================================================================
module cache_set #(
    parameter int WAYS   = 8,
    parameter int SET_ID = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   enable,
    input  logic [2:0]   write_en,
    input  logic [5:0]   block_offset,
    input  logic [5:0]   set_n,
    input  logic [63:0]  write_data,
    input  logic [1:0]   data_size,
    input  logic [23:0]  tag,
    input  logic [31:0]  num_ops,
    output logic [127:0] out_data,
    output logic [1:0]   miss_w,
    output logic [1:0]   miss_r,
    output logic [1:0]   data_ready
);

    localparam int LINE_BITS = 512;

    logic [LINE_BITS-1:0] data_q [WAYS];
    logic [LINE_BITS-1:0] data_d [WAYS];
    logic [23:0]          tag_q  [WAYS];
    logic [23:0]          tag_d  [WAYS];
    logic [2:0]           age_q  [WAYS];
    logic [2:0]           age_d  [WAYS];
    logic [WAYS-1:0]      valid_q, valid_d;
    logic [63:0]          rdata_q, rdata_d;
    logic                 miss_w_q, miss_w_d;
    logic                 miss_r_q, miss_r_d;
    logic                 ready_q, ready_d;

    logic                 w_sel, w_flush, w_rd, w_wr;
    logic                 w_hit;
    logic [2:0]           w_hit_way, w_victim, w_touch;
    logic [63:0]          w_span_rd;
    logic [LINE_BITS-1:0] w_line;

    // Debug-only inputs folded into a sink so they carry no function.
    logic unused_ok;
    assign unused_ok = ^{num_ops, enable[1]};

    assign w_sel   = (set_n == 6'(SET_ID));
    assign w_flush = w_sel && enable[0];
    assign w_rd    = w_sel && !enable[0] && (write_en == 3'd0);
    assign w_wr    = w_sel && !enable[0] && (write_en == 3'd1);
    assign w_touch = w_hit ? w_hit_way : w_victim;

    // Hit detection and victim choice. The descending scan over invalid
    // ways runs last, so the lowest invalid way overrides the age-7 way.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = 3'd0;
        w_victim  = 3'd0;
        for (int i = 0; i < WAYS; i++) begin
            if (valid_q[i] && (tag_q[i] == tag)) begin
                w_hit     = 1'b1;
                w_hit_way = 3'(i);
            end
        end
        for (int i = 0; i < WAYS; i++) begin
            if (age_q[i] == 3'd7) w_victim = 3'(i);
        end
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_q[i]) w_victim = 3'(i);
        end
    end

    // Span gather (read) and merge (write). Bytes past index 63 are
    // dropped: idx[6] marks a byte that has run off the end of the line.
    always_comb begin : span_logic
        logic [6:0] idx;
        idx       = '0;
        w_span_rd = '0;
        w_line    = w_hit ? data_q[w_hit_way] : '0;
        for (int k = 0; k < 8; k++) begin
            idx = 7'(block_offset) + 7'(k);
            if ((k < (1 << data_size)) && !idx[6]) begin
                w_span_rd[k*8 +: 8]                = data_q[w_hit_way][{idx[5:0], 3'b000} +: 8];
                w_line[{idx[5:0], 3'b000} +: 8]    = write_data[k*8 +: 8];
            end
        end
    end

    always_comb begin
        data_d   = data_q;
        tag_d    = tag_q;
        valid_d  = valid_q;
        age_d    = age_q;
        rdata_d  = rdata_q;
        miss_w_d = miss_w_q;
        miss_r_d = miss_r_q;
        ready_d  = ready_q;
        if (w_flush) begin
            valid_d  = '0;
            rdata_d  = '0;
            miss_w_d = 1'b0;
            miss_r_d = 1'b0;
            ready_d  = 1'b0;
            for (int i = 0; i < WAYS; i++) age_d[i] = 3'(i);
        end else if (w_rd) begin
            rdata_d  = w_hit ? w_span_rd : 64'd0;
            ready_d  = w_hit;
            miss_r_d = !w_hit;
            miss_w_d = 1'b0;
        end else if (w_wr) begin
            data_d[w_touch]  = w_line;
            tag_d[w_touch]   = tag;
            valid_d[w_touch] = 1'b1;
            miss_w_d         = !w_hit;
            miss_r_d         = 1'b0;
            ready_d          = 1'b0;
        end
        // The touched way goes to age 0; only younger ways age by one, so
        // the ages remain a permutation of 0..7.
        if (!w_flush && (w_wr || (w_rd && w_hit))) begin
            for (int i = 0; i < WAYS; i++) begin
                if (3'(i) == w_touch)
                    age_d[i] = 3'd0;
                else if (age_q[i] < age_q[w_touch])
                    age_d[i] = age_q[i] + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WAYS; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
                age_q[i]  <= 3'(i);
            end
            valid_q  <= '0;
            rdata_q  <= '0;
            miss_w_q <= 1'b0;
            miss_r_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            data_q   <= data_d;
            tag_q    <= tag_d;
            age_q    <= age_d;
            valid_q  <= valid_d;
            rdata_q  <= rdata_d;
            miss_w_q <= miss_w_d;
            miss_r_q <= miss_r_d;
            ready_q  <= ready_d;
        end
    end

    assign out_data   = {64'd0, rdata_q};
    assign miss_w     = {1'b0, miss_w_q};
    assign miss_r     = {1'b0, miss_r_q};
    assign data_ready = {1'b0, ready_q};

endmodule
`default_nettype wire

// File: tb/tb_cache_set.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_set
// Purpose  : Scoreboard bench for cache_set. A reference model built from
//            byte arrays and an LRU recency list predicts every response.
//            A monitor compares those predictions against the DUT outputs
//            in the cycle where each response is due.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_set;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   enable = '0;
    logic [2:0]   write_en = 3'd7;
    logic [5:0]   block_offset = '0;
    logic [5:0]   set_n = '0;
    logic [63:0]  write_data = '0;
    logic [1:0]   data_size = '0;
    logic [23:0]  tag = '0;
    logic [31:0]  num_ops = '0;
    logic [127:0] out_data;
    logic [1:0]   miss_w, miss_r, data_ready;

    cache_set #(.WAYS(8), .SET_ID(0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .write_en(write_en),
        .block_offset(block_offset), .set_n(set_n), .write_data(write_data),
        .data_size(data_size), .tag(tag), .num_ops(num_ops),
        .out_data(out_data), .miss_w(miss_w), .miss_r(miss_r),
        .data_ready(data_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    logic        m_valid [8];
    logic [23:0] m_tag   [8];
    logic [7:0]  m_data  [8][64];
    int          m_lru[$];        // way indices, most recently used first
    logic [63:0] m_out;
    logic        m_mw, m_mr, m_rdy;

    function automatic void m_touch(input int w);
        for (int i = 0; i < m_lru.size(); i++)
            if (m_lru[i] == w) begin m_lru.delete(i); break; end
        m_lru.push_front(w);
    endfunction

    function automatic void m_reset_lru();
        m_lru.delete();
        for (int i = 0; i < 8; i++) m_lru.push_back(i);
    endfunction

    function automatic void model(input logic [1:0] en, input logic [2:0] we, input int off,
                                  input int sn, input logic [63:0] wd, input int sz, input logic [23:0] tg);
        int len, w, v;
        len = 1 << sz;
        if (sn != 0) return;
        if (en[0]) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
            m_reset_lru();
            m_out = '0; m_mw = 0; m_mr = 0; m_rdy = 0;
            return;
        end
        w = -1;
        for (int i = 0; i < 8; i++) if (m_valid[i] && m_tag[i] == tg) w = i;
        if (we == 3'd0) begin
            m_mw = 0;
            if (w >= 0) begin
                m_out = '0;
                for (int k = 0; k < len; k++)
                    if (off + k < 64) m_out[k*8 +: 8] = m_data[w][off + k];
                m_rdy = 1; m_mr = 0;
                m_touch(w);
            end else begin
                m_out = '0; m_rdy = 0; m_mr = 1;
            end
        end else if (we == 3'd1) begin
            m_mr = 0; m_rdy = 0;
            if (w >= 0) begin
                m_mw = 0;
            end else begin
                v = -1;
                for (int i = 7; i >= 0; i--) if (!m_valid[i]) v = i;
                if (v < 0) v = m_lru[$];
                for (int b = 0; b < 64; b++) m_data[v][b] = 8'h00;
                m_tag[v] = tg; m_valid[v] = 1'b1;
                m_mw = 1; w = v;
            end
            for (int k = 0; k < len; k++)
                if (off + k < 64) m_data[w][off + k] = wd[k*8 +: 8];
            m_touch(w);
        end
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int           due;
        logic [127:0] d;
        logic [1:0]   mw, mr, rdy;
    } exp_t;
    exp_t exp_q[$];

    task automatic req(input logic [1:0] en, input logic [2:0] we, input int off, input int sn,
                       input logic [63:0] wd, input int sz, input logic [23:0] tg);
        exp_t e;
        @(negedge clk);
        enable = en; write_en = we; block_offset = 6'(off); set_n = 6'(sn);
        write_data = wd; data_size = 2'(sz); tag = tg; num_ops = num_ops + 1;
        model(en, we, off, sn, wd, sz, tg);
        e.due = cyc + 1;
        e.d   = {64'd0, m_out};
        e.mw  = {1'b0, m_mw};
        e.mr  = {1'b0, m_mr};
        e.rdy = {1'b0, m_rdy};
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            if (e.due < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL stale_expectation due %0d at cycle %0d", e.due, cyc);
            end else begin
                check("out_data",   out_data,            e.d);
                check("miss_w",     128'(miss_w),        128'(e.mw));
                check("miss_r",     128'(miss_r),        128'(e.mr));
                check("data_ready", 128'(data_ready),    128'(e.rdy));
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_tag[i] = '0;
            for (int b = 0; b < 64; b++) m_data[i][b] = 8'h00;
        end
        m_reset_lru();
        m_out = '0; m_mw = 0; m_mr = 0; m_rdy = 0;

        repeat (3) @(negedge clk);
        check("reset_out_data",   out_data,         128'd0);
        check("reset_miss_w",     128'(miss_w),     128'd0);
        check("reset_miss_r",     128'(miss_r),     128'd0);
        check("reset_data_ready", 128'(data_ready), 128'd0);
        rst_n = 1'b1;

        // Directed sequence
        req(2'b01, 3'd7, 0, 0, 64'd0, 0, 24'd0);          // flush
        req(2'b00, 3'd0, 0, 0, 64'd0, 3, 24'd15);         // read miss
        req(2'b00, 3'd1, 0, 0, 64'd8, 3, 24'd15);         // write miss
        req(2'b00, 3'd0, 0, 0, 64'd0, 3, 24'd15);         // read hit -> 8
        req(2'b00, 3'd5, 0, 0, 64'd0, 0, 24'd0);          // no-op holds
        req(2'b00, 3'd1, 0, 0, 64'd3, 0, 24'd16);
        req(2'b00, 3'd1, 0, 0, 64'd8, 0, 24'd25);
        req(2'b00, 3'd0, 0, 0, 64'd0, 0, 24'd16);         // -> 3
        req(2'b00, 3'd0, 0, 0, 64'd0, 3, 24'd19);         // miss
        req(2'b00, 3'd1, 0, 0, 64'h1122334455667788, 3, 24'd15);
        req(2'b00, 3'd1, 0, 0, 64'hAA, 0, 24'd15);        // write hit
        req(2'b00, 3'd0, 0, 0, 64'd0, 3, 24'd15);         // 0x11223344556677AA
        req(2'b00, 3'd1, 62, 0, 64'hFFFF, 3, 24'd15);     // tail dropped
        req(2'b00, 3'd0, 62, 0, 64'd0, 3, 24'd15);        // 0xFFFF
        req(2'b01, 3'd1, 0, 0, 64'd0, 0, 24'd0);          // flush beats write
        for (int t = 1; t <= 8; t++) req(2'b00, 3'd1, 0, 0, 64'(t), 3, 24'(t));
        req(2'b00, 3'd0, 0, 0, 64'd0, 3, 24'd1);
        req(2'b00, 3'd1, 0, 0, 64'd9, 3, 24'd9);          // evicts tag 2
        req(2'b00, 3'd0, 0, 0, 64'd0, 3, 24'd2);          // miss
        req(2'b00, 3'd0, 0, 0, 64'd0, 3, 24'd1);          // hit
        req(2'b01, 3'd1, 0, 5, 64'd77, 3, 24'd1);         // other set: ignored
        req(2'b00, 3'd1, 0, 5, 64'd77, 3, 24'd1);         // other set: ignored
        req(2'b00, 3'd0, 0, 0, 64'd0, 3, 24'd1);          // still original data

        // Random phase
        for (int n = 0; n < 3000; n++) begin
            int r, off, sn;
            logic [1:0] en;
            logic [2:0] we;
            r   = $urandom_range(0, 99);
            en  = (r < 2) ? 2'b01 : {1'($urandom_range(0, 1)), 1'b0};
            r   = $urandom_range(0, 99);
            we  = (r < 40) ? 3'd0 : (r < 80) ? 3'd1 : 3'($urandom_range(2, 7));
            sn  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 63) : 0;
            off = ($urandom_range(0, 3) == 0) ? $urandom_range(56, 63) : $urandom_range(0, 63);
            req(en, we, off, sn, {$urandom, $urandom}, $urandom_range(0, 3),
                24'($urandom_range(0, 11)));
        end

        // Drain the scoreboard within a bounded number of cycles.
        @(negedge clk);
        enable = '0; write_en = 3'd7;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
